thread_sched: RTL and testbench
===============================

// Module: thread_sched
// PURPOSE
//  Hardware-thread scheduler for the barrel core; replaces the fixed round-robin thread timer.
//  Tracks per-thread state (idle/run/wait-mem/halted) and picks one runnable thread per cycle.
//  Uses round-robin among runnable threads and enforces a minimum re-issue gap so one thread
//  never has two instructions in flight. Output feeds ifu thread_id; events come from alu/lsu.
// PARAMETERS
//  NTHREADS  4  number of hardware threads (power of 2, >=2); TID_W = $clog2(NTHREADS)
//  MIN_GAP   4  min cycles between two issues of the same thread (= pipeline depth, >=1)
// PORTS
//  clk             in   1            clock
//  rst             in   1            reset, synchronous, active-low
//  thread_start_i  in   NTHREADS     per-thread start pulse (IDLE/HALT -> RUN)
//  thread_halt_i   in   NTHREADS     per-thread halt request (any -> HALT)
//  illegal_inst_i  in   1            illegal instruction retired by thread illegal_tid_i
//  illegal_tid_i   in   TID_W        thread of illegal instruction
//  mem_req_i       in   1            load/store issued at EXU by mem_req_tid_i
//  mem_req_tid_i   in   TID_W        requesting thread
//  mem_ack_i       in   1            memory response returned for mem_ack_tid_i
//  mem_ack_tid_i   in   TID_W        acknowledged thread
//  issue_valid_o   out  1            issue_tid_o fetches this cycle; 0 = bubble
//  issue_tid_o     out  TID_W        thread to fetch (to ifu thread_id)
//  thread_state_o  out  2*NTHREADS   packed thread_state_t per thread
//  all_idle_o      out  1            no thread in RUN or WAIT
// BEHAVIOUR
//  Reset (rst==0 at edge): thread 0 = TS_RUN, others TS_IDLE; cooldowns 0; rr ptr = NTHREADS-1;
//   issue_valid_o=0, issue_tid_o=0, all_idle_o=0. Reset mid-operation discards all state at that edge.
//  States: TS_IDLE=00, TS_RUN=01, TS_WAIT=10, TS_HALT=11. Per-thread next state, priority order:
//   halt (thread_halt_i[t] | illegal for t) -> HALT;  WAIT & ack(t) -> RUN;
//   RUN & req(t) -> WAIT;  (IDLE|HALT) & start[t] -> RUN;  else hold.
//   Start on RUN/WAIT ignored; req on non-RUN ignored; ack on non-WAIT ignored (bench asserts these).
//   req(t) and ack(u), t!=u, same cycle: both apply.
//  Eligibility uses post-event state (state_d): elig[t] = state_d[t]==TS_RUN && cool[t]==0.
//   So start/ack at cycle k -> thread issuable at the edge ending cycle k (1-cycle latency);
//   req at cycle k -> thread never issued at that edge.
//  Selection: first eligible thread scanning rr_ptr+1 .. rr_ptr (wraps mod NTHREADS).
//   Grant g: issue_valid_o<=1, issue_tid_o<=g, rr_ptr<=g, cool[g]<=MIN_GAP-1.
//   No eligible thread: issue_valid_o<=0, issue_tid_o holds, rr_ptr holds.
//  Cooldown: each nonzero cool[t] decrements by 1 per cycle; saturates at 0; cleared on HALT entry.
//  Outputs registered. thread_state_o = state_q; all_idle_o = no state_q in RUN/WAIT.
// CONFIGURATION
//  SCHED_PERF_EN defined: adds ports perf_sel_i (in, TID_W) and perf_cnt_o (out, 32).
//   perf_cnt_o = registered issue count of thread perf_sel_i, 1-cycle latency.
//   Counters are 32 bit, wrap at 2^32, and reset to 0; a start pulse does not clear them.
//  SCHED_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  cpu_types: thread_state_t enum, NTHREADS, TID_W, thread_id_t typedef.
//  Sub-module rr_arbiter (N-wide rotating-priority arbiter: req vector, ptr -> grant, gnt_valid).
//  The state FSM, cooldown counters and perf counters stay in thread_sched.
// TESTING
//  1 Release reset, no starts, MIN_GAP=4 -> issue_valid 1,0,0,0 repeating, tid 0 only.
//  2 thread_start_i=4'b1110 one cycle -> tids 0,1,2,3,0,1.. with no bubbles.
//  3 All running, mem_req tid2; ack 10 cycles later -> tid2 absent, pattern 0,1,3,bubble;
//    tid2 issues at the first edge after the ack where its slot is next.
//  4 illegal_inst tid1 with mem_ack tid1 same cycle -> state1=2'b11 and never issued;
//    thread_start_i[1] -> RUN, issued within NTHREADS cycles.
//  5 rst low for one cycle mid-stream -> next cycle issue_valid=0, states = reset values;
//    tid0 issues the cycle after rst goes high.
//  6 SCHED_PERF_EN, only tid0 running for 40 cycles, perf_sel=0 -> perf_cnt_o=10;
//    perf_sel=3 -> 0.

Source files
------------

// File: rtl/thread_sched_pkg.sv
// rtl/thread_sched_pkg.sv - shared thread scheduler types, sizes and next-state rule
package thread_sched_pkg;

    localparam int NTHREADS = 4;
    localparam int TID_W    = $clog2(NTHREADS);

    typedef logic [TID_W-1:0] thread_id_t;

    typedef enum logic [1:0] {
        TS_IDLE = 2'b00,
        TS_RUN  = 2'b01,
        TS_WAIT = 2'b10,
        TS_HALT = 2'b11
    } thread_state_t;

    // Event priority: halt, then ack, then req, then start; anything else holds.
    function automatic thread_state_t next_state(
        input thread_state_t cur,
        input logic          halt,
        input logic          ack,
        input logic          req,
        input logic          start
    );
        thread_state_t ns;
        ns = cur;
        if (halt)
            ns = TS_HALT;
        else if (cur == TS_WAIT && ack)
            ns = TS_RUN;
        else if (cur == TS_RUN && req)
            ns = TS_WAIT;
        else if ((cur == TS_IDLE || cur == TS_HALT) && start)
            ns = TS_RUN;
        return ns;
    endfunction

endpackage

// File: rtl/thread_sched_rr_arbiter.sv
// rtl/thread_sched_rr_arbiter.sv - N-wide rotating-priority arbiter, search starts after i_ptr
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_gnt_valid,
    output logic [W-1:0] o_gnt
);

    logic [W-1:0] w_idx;

    // N is a power of two, so W-bit addition wraps the scan naturally.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt       = i_ptr;
        w_idx       = i_ptr;
        for (int i = 1; i <= N; i++) begin
            w_idx = i_ptr + W'(i);
            if (!o_gnt_valid && i_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt       = w_idx;
            end
        end
    end

endmodule

// File: rtl/thread_sched.sv
// rtl/thread_sched.sv - barrel-core thread scheduler; optional issue counters under SCHED_PERF_EN
module thread_sched
    import thread_sched_pkg::*;
#(
    parameter int NTHREADS = thread_sched_pkg::NTHREADS,
    parameter int MIN_GAP  = 4,
    localparam int TW      = $clog2(NTHREADS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NTHREADS-1:0]   thread_start_i,
    input  logic [NTHREADS-1:0]   thread_halt_i,
    input  logic                  illegal_inst_i,
    input  logic [TW-1:0]         illegal_tid_i,
    input  logic                  mem_req_i,
    input  logic [TW-1:0]         mem_req_tid_i,
    input  logic                  mem_ack_i,
    input  logic [TW-1:0]         mem_ack_tid_i,
`ifdef SCHED_PERF_EN
    input  logic [TW-1:0]         perf_sel_i,
    output logic [31:0]           perf_cnt_o,
`endif
    output logic                  issue_valid_o,
    output logic [TW-1:0]         issue_tid_o,
    output logic [2*NTHREADS-1:0] thread_state_o,
    output logic                  all_idle_o
);

    localparam int CW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    thread_state_t       r_state   [NTHREADS];
    thread_state_t       w_state_d [NTHREADS];
    logic [CW-1:0]       r_cool    [NTHREADS];
    logic [NTHREADS-1:0] w_halt;
    logic [NTHREADS-1:0] w_elig;
    logic [TW-1:0]       r_rr_ptr;
    logic                r_issue_valid;
    logic [TW-1:0]       r_issue_tid;
    logic                w_gnt_valid;
    logic [TW-1:0]       w_gnt;

    always_comb begin
        w_halt = '0;
        w_elig = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            w_halt[t]    = thread_halt_i[t] | (illegal_inst_i && illegal_tid_i == TW'(t));
            w_state_d[t] = next_state(r_state[t], w_halt[t],
                                      mem_ack_i && mem_ack_tid_i == TW'(t),
                                      mem_req_i && mem_req_tid_i == TW'(t),
                                      thread_start_i[t]);
            // Post-event state gates issue: a thread requesting memory this cycle is not picked.
            w_elig[t]    = (w_state_d[t] == TS_RUN) && (r_cool[t] == '0);
        end
    end

    rr_arbiter #(.N(NTHREADS)) u_arb (
        .i_req       (w_elig),
        .i_ptr       (r_rr_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt       (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_state[t] <= (t == 0) ? TS_RUN : TS_IDLE;
                r_cool[t]  <= '0;
            end
            r_rr_ptr      <= TW'(NTHREADS - 1);
            r_issue_valid <= 1'b0;
            r_issue_tid   <= '0;
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_state[t] <= w_state_d[t];
                if (w_state_d[t] == TS_HALT && r_state[t] != TS_HALT)
                    r_cool[t] <= '0;
                else if (w_gnt_valid && w_gnt == TW'(t))
                    r_cool[t] <= CW'(MIN_GAP - 1);
                else if (r_cool[t] != '0)
                    r_cool[t] <= r_cool[t] - 1'b1;
            end
            r_issue_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_issue_tid <= w_gnt;
                r_rr_ptr    <= w_gnt;
            end
        end
    end

`ifdef SCHED_PERF_EN
    logic [31:0] r_perf [NTHREADS];
    logic [31:0] r_perf_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < NTHREADS; t++)
                r_perf[t] <= '0;
            r_perf_out <= '0;
        end else begin
            if (w_gnt_valid)
                r_perf[w_gnt] <= r_perf[w_gnt] + 32'd1;
            r_perf_out <= r_perf[perf_sel_i];
        end
    end

    assign perf_cnt_o = r_perf_out;
`endif

    always_comb begin
        all_idle_o = 1'b1;
        for (int t = 0; t < NTHREADS; t++) begin
            thread_state_o[2*t +: 2] = r_state[t];
            if (r_state[t] == TS_RUN || r_state[t] == TS_WAIT)
                all_idle_o = 1'b0;
        end
    end

    assign issue_valid_o = r_issue_valid;
    assign issue_tid_o   = r_issue_tid;

endmodule

// File: tb/tb_thread_sched.sv
// tb/tb_thread_sched.sv - self-checking bench for thread_sched with a cycle-level reference model
module tb_thread_sched;

    localparam int N = 4;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] start = '0;
    logic [N-1:0] halt = '0;
    logic         ill = 1'b0;
    logic [1:0]   ill_tid = '0;
    logic         req = 1'b0;
    logic [1:0]   req_tid = '0;
    logic         ack = 1'b0;
    logic [1:0]   ack_tid = '0;
    logic         iv;
    logic [1:0]   itid;
    logic [2*N-1:0] tst;
    logic         aidle;
`ifdef SCHED_PERF_EN
    logic [1:0]   psel = '0;
    logic [31:0]  pcnt;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    thread_sched #(.NTHREADS(N), .MIN_GAP(G)) dut (
        .clk            (clk),
        .rst            (rst),
        .thread_start_i (start),
        .thread_halt_i  (halt),
        .illegal_inst_i (ill),
        .illegal_tid_i  (ill_tid),
        .mem_req_i      (req),
        .mem_req_tid_i  (req_tid),
        .mem_ack_i      (ack),
        .mem_ack_tid_i  (ack_tid),
`ifdef SCHED_PERF_EN
        .perf_sel_i     (psel),
        .perf_cnt_o     (pcnt),
`endif
        .issue_valid_o  (iv),
        .issue_tid_o    (itid),
        .thread_state_o (tst),
        .all_idle_o     (aidle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: issue spacing tracked as "edges since last issue" per thread.
    int     m_st   [N];
    longint m_last [N];
    int     m_perf [N];
    int     m_rr;
    bit     m_v;
    int     m_tid;
    int     m_pout;
    longint m_cyc = 0;
    bit     m_ok = 0;

    always @(posedge clk) begin
        int ns [N];
        bit found;
        int g;
        if (!rst) begin
            for (int t = 0; t < N; t++) begin
                m_st[t]   = (t == 0) ? 1 : 0;
                m_last[t] = -1000;
                m_perf[t] = 0;
            end
            m_rr = N - 1; m_v = 0; m_tid = 0; m_pout = 0; m_ok = 1;
        end else begin
            for (int t = 0; t < N; t++) begin
                if (halt[t] || (ill && ill_tid == t))              ns[t] = 3;
                else if (m_st[t] == 2 && ack && ack_tid == t)       ns[t] = 1;
                else if (m_st[t] == 1 && req && req_tid == t)       ns[t] = 2;
                else if ((m_st[t] == 0 || m_st[t] == 3) && start[t]) ns[t] = 1;
                else                                                ns[t] = m_st[t];
            end
            found = 0; g = 0;
            for (int i = 1; i <= N; i++) begin
                int t;
                t = (m_rr + i) % N;
                if (!found && ns[t] == 1 && (m_cyc - m_last[t]) >= G) begin
                    found = 1; g = t;
                end
            end
`ifdef SCHED_PERF_EN
            m_pout = m_perf[psel];
`endif
            m_v = found;
            if (found) begin
                m_tid = g; m_rr = g; m_last[g] = m_cyc; m_perf[g]++;
            end
            for (int t = 0; t < N; t++) begin
                if (ns[t] == 3 && m_st[t] != 3) m_last[t] = -1000;
                m_st[t] = ns[t];
            end
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        logic [2*N-1:0] exp_st;
        bit exp_idle;
        if (m_ok) begin
            exp_idle = 1;
            for (int t = 0; t < N; t++) begin
                exp_st[2*t +: 2] = 2'(m_st[t]);
                if (m_st[t] == 1 || m_st[t] == 2) exp_idle = 0;
            end
            chk("model_valid", 32'(iv), 32'(m_v));
            chk("model_tid", 32'(itid), 32'(m_tid));
            chk("model_state", 32'(tst), 32'(exp_st));
            chk("model_all_idle", 32'(aidle), 32'(exp_idle));
`ifdef SCHED_PERF_EN
            chk("model_perf", pcnt, 32'(m_pout));
`endif
        end
    end

    initial begin
        int cnt;
        int c2;
        bit found;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(iv), 0);
        chk("rst_tid", 32'(itid), 0);
        chk("rst_state", 32'(tst), 32'h01);
        chk("rst_all_idle", 32'(aidle), 0);

        // Only thread 0 running: issue every 4th cycle.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_valid", 32'(iv), (i % 4 == 0) ? 1 : 0);
            chk("t1_tid", 32'(itid), 0);
        end

        // Ignored events: req on IDLE thread 3, ack on RUN thread 0, start on RUN thread 0.
        req = 1'b1; req_tid = 2'd3; ack = 1'b1; ack_tid = 2'd0; start = 4'b0001;
        @(negedge clk);
        req = 1'b0; ack = 1'b0; start = '0;
        chk("ignored_state", 32'(tst), 32'h01);

        // Start threads 1..3: full rotation with no bubbles.
        start = 4'b1110;
        @(negedge clk);
        start = '0;
        chk("t2_state", 32'(tst), 32'h55);
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid", 32'(iv), 1);
            chk("t2_tid", 32'(itid), 32'((i + 1) % 4));
            @(negedge clk);
        end

        // Thread 2 waits on memory: 3 issues per 4 cycles, tid 2 absent.
        req = 1'b1; req_tid = 2'd2;
        @(negedge clk);
        req = 1'b0;
        chk("t3_state_wait", 32'(tst[5:4]), 32'h2);
        cnt = 0; c2 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (iv) cnt++;
            if (iv && itid == 2'd2) c2++;
        end
        chk("t3_valid_cnt", 32'(cnt), 6);
        chk("t3_no_tid2", 32'(c2), 0);
        @(negedge clk);
        ack = 1'b1; ack_tid = 2'd2;
        @(negedge clk);
        ack = 1'b0;
        chk("t3_state_run", 32'(tst[5:4]), 32'h1);
        found = 0;
        for (int i = 0; i < 8; i++) begin
            if (iv && itid == 2'd2) found = 1;
            @(negedge clk);
        end
        chk("t3_tid2_back", 32'(found), 1);

        // Illegal on thread 1 with a same-cycle ack: halt wins.
        ill = 1'b1; ill_tid = 2'd1; ack = 1'b1; ack_tid = 2'd1;
        @(negedge clk);
        ill = 1'b0; ack = 1'b0;
        chk("t4_state_halt", 32'(tst[3:2]), 32'h3);
        c2 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (iv && itid == 2'd1) c2++;
        end
        chk("t4_no_tid1", 32'(c2), 0);
        start = 4'b0010;
        @(negedge clk);
        start = '0;
        chk("t4_state_run", 32'(tst[3:2]), 32'h1);
        found = 0;
        for (int i = 0; i < N; i++) begin
            if (iv && itid == 2'd1) found = 1;
            @(negedge clk);
        end
        chk("t4_tid1_back", 32'(found), 1);

        // Halt everyone: all idle, then bubbles.
        halt = 4'b1111;
        @(negedge clk);
        halt = '0;
        chk("halt_all_state", 32'(tst), 32'hFF);
        chk("halt_all_idle", 32'(aidle), 1);
        @(negedge clk);
        chk("halt_all_bubble", 32'(iv), 0);

        // Mid-stream reset pulse.
        start = 4'b1111;
        @(negedge clk);
        start = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(iv), 0);
        chk("t5_state", 32'(tst), 32'h01);
        chk("t5_tid", 32'(itid), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_issue_valid", 32'(iv), 1);
        chk("t5_issue_tid", 32'(itid), 0);

`ifdef SCHED_PERF_EN
        psel = 2'd0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_perf0", pcnt, 32'd10);
        psel = 2'd3;
        @(negedge clk);
        chk("t6_perf3", pcnt, 32'd0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
